// File: rtl/load_ext_pkg.sv
// Shared types and helpers for the mipsel32 load-result formatter and its
// output buffer.
package load_ext_pkg;

    localparam int MODE_W     = 3;
    localparam int LOAD_TAG_W = 5;

    typedef enum logic [MODE_W-1:0] {
        MODE_LB  = 3'd0,
        MODE_LBU = 3'd1,
        MODE_LH  = 3'd2,
        MODE_LHU = 3'd3,
        MODE_LW  = 3'd4,
        MODE_LWL = 3'd5,
        MODE_LWR = 3'd6,
        MODE_ILL = 3'd7
    } load_mode_e;

    // Buffered entry at the default tag width; the pipe re-declares it at TAG_W.
    typedef struct packed {
        logic [31:0]           data;
        logic                  err;
        logic [LOAD_TAG_W-1:0] tag;
    } load_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << result) < value) begin
                result = result + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/load_format.sv
// Combinational load formatter: byte-lane select, sign/zero extension,
// LWL/LWR merge with the old rt value, and address/mode error detection.
module load_format
    import load_ext_pkg::*;
(
    input  logic [MODE_W-1:0] mode_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [31:0]       mem_word_i,
    input  logic [31:0]       rt_old_i,
    output logic [31:0]       data_o,
    output logic              err_o
);

    load_mode_e  mode_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign mode_s = load_mode_e'(mode_i);
    assign half_s = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    // Byte lane picked by the low address bits (little-endian).
    always_comb begin
        byte_s = 8'd0;
        case (addr_lo_i)
            2'd0:    byte_s = mem_word_i[7:0];
            2'd1:    byte_s = mem_word_i[15:8];
            2'd2:    byte_s = mem_word_i[23:16];
            default: byte_s = mem_word_i[31:24];
        endcase
    end

    // Result formatting; an error forces the data to zero.
    always_comb begin
        data_o = 32'd0;
        err_o  = 1'b0;
        case (mode_s)
            MODE_LB:  data_o = {{24{byte_s[7]}}, byte_s};
            MODE_LBU: data_o = {24'd0, byte_s};
            MODE_LH: begin
                if (addr_lo_i[0]) begin
                    err_o = 1'b1;
                end else begin
                    data_o = {{16{half_s[15]}}, half_s};
                end
            end
            MODE_LHU: begin
                if (addr_lo_i[0]) begin
                    err_o = 1'b1;
                end else begin
                    data_o = {16'd0, half_s};
                end
            end
            MODE_LW: begin
                if (addr_lo_i != 2'd0) begin
                    err_o = 1'b1;
                end else begin
                    data_o = mem_word_i;
                end
            end
            MODE_LWL: begin
                case (addr_lo_i)
                    2'd0:    data_o = {mem_word_i[7:0],  rt_old_i[23:0]};
                    2'd1:    data_o = {mem_word_i[15:0], rt_old_i[15:0]};
                    2'd2:    data_o = {mem_word_i[23:0], rt_old_i[7:0]};
                    default: data_o = mem_word_i;
                endcase
            end
            MODE_LWR: begin
                case (addr_lo_i)
                    2'd0:    data_o = mem_word_i;
                    2'd1:    data_o = {rt_old_i[31:24], mem_word_i[31:8]};
                    2'd2:    data_o = {rt_old_i[31:16], mem_word_i[31:16]};
                    default: data_o = {rt_old_i[31:8],  mem_word_i[31:24]};
                endcase
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_extend_pipe.sv
// Load-result formatter followed by a DEPTH-entry valid/ready FIFO that
// decouples data-SRAM response timing from writeback stalls.
module load_extend_pipe
    import load_ext_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [1:0]        in_addr_lo,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [31:0]       in_rt_old,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_err,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]      data;
        logic             err;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0]      fmt_data_s;
    logic             fmt_err_s;
    entry_t           wr_entry_s;
    entry_t           head_s;
    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    load_format u_format (
        .mode_i     (in_mode),
        .addr_lo_i  (in_addr_lo),
        .mem_word_i (in_data),
        .rt_old_i   (in_rt_old),
        .data_o     (fmt_data_s),
        .err_o      (fmt_err_s)
    );

    // Handshake flags come only from the registered count, never from out_ready.
    assign in_ready   = (count_q != CNT_FULL);
    assign out_valid  = (count_q != {CNT_W{1'b0}});
    assign push_s     = in_valid && in_ready && !flush;
    assign pop_s      = out_valid && out_ready && !flush;
    assign wr_entry_s = '{data: fmt_data_s, err: fmt_err_s, tag: in_tag};

    assign head_s    = mem_q[rd_ptr_q];
    assign out_data  = head_s.data;
    assign out_err   = head_s.err;
    assign out_tag   = head_s.tag;

    // Next-state for pointers, occupancy and storage; flush overrides traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = wr_entry_s;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears storage so outputs read zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
